uart_tx_fifo_param: RTL and testbench

Parametrised successor to the fixed 8N1 UART transmitter.
- Configurable data width, parity mode and stop-bit count.
- Small synchronous TX FIFO with valid/ready input handshake, so the SDRAM readback path can stream bytes without polling busy.
- Sits between the SDRAM read/format logic and the board TX pin on DE1-SoC.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_sync_fifo.sv | 59 +++++
 rtl/uart_tx_fifo_param.sv | 135 +++++++++++++
 tb/tb_uart_tx_fifo_param.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART transmit and receive blocks
//   uart_state_e : serializer state encoding
//   PAR_*        : parity mode encodings used by the PARITY parameter
//   baud_tick()  : clocks per bit time
//   cnt_width()  : register width able to count 0..n-1
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int baud_tick(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // A counter of 0..n-1 needs at least one bit, even for n = 1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with registered occupancy count
//   clk, rst_n : clock, synchronous active-low reset (flushes the FIFO)
//   push       : write wr_data (ignored when full)
//   wr_data    : word to store
//   pop        : drop the head entry (ignored when empty)
//   rd_data    : current head entry, valid while !empty
//   full/empty : derived from the registered count
//   count      : occupancy, 0..DEPTH
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_sync_fifo: DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = count == (AW + 1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// uart_tx_fifo_param: parametrised UART transmitter fed by a small TX FIFO
//   clk, rst_n : clock, synchronous active-low reset
//   in_data    : word to send, LSB first on the line
//   in_valid   : in_data valid; transfer when in_valid & in_ready at a rising edge
//   in_ready   : FIFO has room (low while in reset)
//   tx         : serial line, idle high
//   busy       : a frame is in progress or words are queued
//   fifo_count : FIFO occupancy
module uart_tx_fifo_param #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    import uart_pkg::*;

    localparam int BAUD_TICK = baud_tick(CLK_FREQ, BAUD_RATE);
    localparam int STOP_LEN  = STOP_BITS * BAUD_TICK;
    localparam int CW        = cnt_width(STOP_LEN);
    localparam int BW        = cnt_width(DATA_BITS);
    localparam bit HAS_PAR   = PARITY != PAR_NONE;

    if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY < 0 || PARITY > 2 || BAUD_TICK < 2) begin : g_bad_param
        $error("uart_tx_fifo_param: illegal parameter combination");
    end

    uart_state_e          state;
    uart_state_e          state_next;
    logic [CW-1:0]        baud_cnt;
    logic [CW-1:0]        baud_next;
    logic [BW-1:0]        bit_cnt;
    logic [BW-1:0]        bit_next;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_next;
    logic [DATA_BITS-1:0] fifo_head;
    logic                 par_bit;
    logic                 par_next;
    logic                 tx_next;
    logic                 pop;
    logic                 push;
    logic                 bit_end;
    logic                 last_bit;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 ready_en;

    // ready_en keeps in_ready low during reset and for the reset edge itself.
    assign in_ready = ready_en & ~fifo_full;
    assign push     = in_valid & in_ready;
    // The whole stop period is one counter run, so STOP_BITS needs no extra counter.
    assign bit_end  = (state == S_STOP) ? baud_cnt == CW'(STOP_LEN - 1)
                                        : baud_cnt == CW'(BAUD_TICK - 1);
    assign last_bit = bit_cnt == BW'(DATA_BITS - 1);

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (in_data),
        .pop     (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            ready_en <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            shreg    <= shreg_next;
            par_bit  <= par_next;
            tx       <= tx_next;
            // Rises with the start bit, falls as the line returns to idle.
            busy     <= (state_next != S_IDLE) | ~fifo_empty;
            ready_en <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                pop        = ~fifo_empty;
                state_next = fifo_empty ? S_IDLE : S_START;
            end
            S_START:  state_next = bit_end ? S_DATA : S_START;
            S_DATA:   state_next = (bit_end && last_bit) ? (HAS_PAR ? S_PARITY : S_STOP) : S_DATA;
            S_PARITY: state_next = bit_end ? S_STOP : S_PARITY;
            S_STOP: begin
                // Back-to-back frames: next start bit follows the stop period directly.
                pop        = bit_end & ~fifo_empty;
                state_next = !bit_end ? S_STOP : (fifo_empty ? S_IDLE : S_START);
            end
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        baud_next  = (state == S_IDLE || bit_end) ? '0 : baud_cnt + CW'(1);
        bit_next   = (state == S_DATA && bit_end) ? (last_bit ? '0 : bit_cnt + BW'(1)) : bit_cnt;
        shreg_next = pop ? fifo_head : (state == S_DATA && bit_end) ? shreg >> 1 : shreg;
        par_next   = pop ? (^fifo_head) ^ (PARITY == PAR_ODD) : par_bit;
        tx_next    = (state_next == S_START)  ? 1'b0 :
                     (state_next == S_DATA)   ? shreg_next[0] :
                     (state_next == S_PARITY) ? par_bit : 1'b1;
    end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// tb_uart_tx_fifo_param: scoreboard bench over four UART configurations at 4 clk/bit
module tb_uart_tx_fifo_param;

    localparam int BT = 4;

    typedef struct {
        int         line;
        logic [8:0] data;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] din [4];
    logic [3:0] vld;
    logic [3:0] rdy;
    logic [3:0] tx_v;
    logic [3:0] busy_v;
    logic [2:0] cnt_a;
    logic [4:0] cnt_b;
    logic [4:0] cnt_c;
    logic [4:0] cnt_d;
    sb_t        sb [$];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    // line 0: 8N1 depth 4, line 1: 8E1, line 2: 8O1, line 3: 7 data bits + 2 stop
    uart_tx_fifo_param #(.CLK_FREQ(1_000_000), .BAUD_RATE(250_000), .DATA_BITS(8),
                         .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(din[0][7:0]), .in_valid(vld[0]), .in_ready(rdy[0]),
        .tx(tx_v[0]), .busy(busy_v[0]), .fifo_count(cnt_a));
    uart_tx_fifo_param #(.CLK_FREQ(1_000_000), .BAUD_RATE(250_000), .DATA_BITS(8),
                         .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(din[1][7:0]), .in_valid(vld[1]), .in_ready(rdy[1]),
        .tx(tx_v[1]), .busy(busy_v[1]), .fifo_count(cnt_b));
    uart_tx_fifo_param #(.CLK_FREQ(1_000_000), .BAUD_RATE(250_000), .DATA_BITS(8),
                         .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u_c (
        .clk(clk), .rst_n(rst_n), .in_data(din[2][7:0]), .in_valid(vld[2]), .in_ready(rdy[2]),
        .tx(tx_v[2]), .busy(busy_v[2]), .fifo_count(cnt_c));
    uart_tx_fifo_param #(.CLK_FREQ(1_000_000), .BAUD_RATE(250_000), .DATA_BITS(7),
                         .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)) u_d (
        .clk(clk), .rst_n(rst_n), .in_data(din[3][6:0]), .in_valid(vld[3]), .in_ready(rdy[3]),
        .tx(tx_v[3]), .busy(busy_v[3]), .fifo_count(cnt_d));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line decoder: samples every negedge, requires each bit to hold for exactly BT clocks.
    for (genvar g = 0; g < 4; g++) begin : g_mon
        localparam int NB = (g == 3) ? 7 : 8;
        localparam int PM = (g == 1) ? 2 : (g == 2) ? 1 : 0;
        localparam int SB = (g == 3) ? 2 : 1;
        initial begin : mon
            logic [8:0] w;
            logic [8:0] m;
            logic       ok;
            logic       bad;
            logic       p;
            logic       ep;
            sb_t        e;
            m = 9'((1 << NB) - 1);
            forever begin
                @(negedge clk);
                if (rst_n && !tx_v[g]) begin
                    w = '0; ok = 1'b1; bad = 1'b0; p = 1'b0;
                    for (int i = 1; i < BT; i++) begin
                        @(negedge clk); bad |= !rst_n; ok &= !tx_v[g];
                    end
                    for (int b = 0; b < NB; b++)
                        for (int i = 0; i < BT; i++) begin
                            @(negedge clk); bad |= !rst_n;
                            if (i == 0) w[b] = tx_v[g]; else ok &= (tx_v[g] == w[b]);
                        end
                    for (int i = 0; i < ((PM != 0) ? BT : 0); i++) begin
                        @(negedge clk); bad |= !rst_n;
                        if (i == 0) p = tx_v[g]; else ok &= (tx_v[g] == p);
                    end
                    for (int i = 0; i < SB * BT; i++) begin
                        @(negedge clk); bad |= !rst_n; ok &= tx_v[g];
                    end
                    if (!bad) begin
                        if (sb.size() > 0) e = sb.pop_front();
                        else begin e.line = -1; e.data = '1; end
                        ep = (PM == 2) ? ^(e.data & m) : (PM == 1) ? ~^(e.data & m) : 1'b0;
                        check($sformatf("L%0d line", g), g, e.line);
                        check($sformatf("L%0d data", g), w, e.data);
                        check($sformatf("L%0d parity", g), p, ep);
                        check($sformatf("L%0d framing", g), ok, 1);
                    end
                end
            end
        end
    end

    // Called away from the edge; leaves in_valid high after the accepting edge.
    task automatic push(input int g, input logic [8:0] d);
        int n = 0;
        din[g] = d;
        vld[g] = 1'b1;
        while (!rdy[g] && n < 500) begin @(posedge clk); #1; n++; end
        check("push ready timeout", n < 500, 1);
        @(posedge clk); #1;
        sb.push_back('{line: g, data: d});
    endtask

    task automatic run_one(input int g, input logic [8:0] d, input int len);
        int n = 0;
        push(g, d);
        vld[g] = 1'b0;
        check($sformatf("L%0d busy at accept", g), busy_v[g], 0);
        check($sformatf("L%0d tx at accept", g), tx_v[g], 1);
        @(posedge clk); #1;
        check($sformatf("L%0d start bit", g), tx_v[g], 0);
        while (busy_v[g] && n < 500) begin @(posedge clk); #1; n++; end
        check($sformatf("L%0d busy length", g), n, len);
        check($sformatf("L%0d tx idle", g), tx_v[g], 1);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  n;
        int  k;
        logic acc;
        rst_n = 1'b0;
        vld   = '0;
        for (int i = 0; i < 4; i++) din[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset tx", tx_v, 4'hF);
        check("reset busy", busy_v, 4'h0);
        check("reset ready", rdy, 4'h0);
        check("reset count", cnt_a, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready after reset", rdy, 4'hF);

        run_one(0, 9'h0A5, 40);
        run_one(1, 9'h055, 44);
        run_one(2, 9'h055, 44);
        run_one(3, 9'h041, 40);

        // Burst of three: contiguous frames, count 1,1,2 as the first word pops immediately.
        push(0, 9'h011); check("burst count 1", cnt_a, 1);
        push(0, 9'h022); check("burst count 2", cnt_a, 1);
        push(0, 9'h033); check("burst count 3", cnt_a, 2);
        vld[0] = 1'b0;
        n = 0;
        while (busy_v[0] && n < 500) begin @(posedge clk); #1; n++; end
        check("burst busy tail", n, 119);

        // Depth-4 fill with in_valid held high.
        k = 0;
        din[0] = 9'h0C0;
        vld[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            acc = rdy[0];
            @(posedge clk); #1;
            if (acc) begin sb.push_back('{line: 0, data: din[0]}); k++; din[0] = 9'h0C0 + 9'(k); end
        end
        check("fill accepted", k, 5);
        check("fill ready low", rdy[0], 0);
        check("fill count", cnt_a, 4);
        n = 0;
        while (k < 8 && n < 1000) begin
            acc = rdy[0];
            @(posedge clk); #1;
            n++;
            if (acc) begin sb.push_back('{line: 0, data: din[0]}); k++; din[0] = 9'h0C0 + 9'(k); end
        end
        vld[0] = 1'b0;
        check("fill all accepted", k, 8);
        n = 0;
        while (busy_v[0] && n < 1000) begin @(posedge clk); #1; n++; end
        check("fill drained", cnt_a, 0);
        check("fill busy drop", busy_v[0], 0);

        // Reset in the middle of the first data bit with another word queued.
        push(0, 9'h096);
        push(0, 9'h05A);
        vld[0] = 1'b0;
        check("pre-reset count", cnt_a, 1);
        repeat (6) @(posedge clk);
        #1;
        check("pre-reset tx low", tx_v[0], 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid reset tx", tx_v[0], 1);
        check("mid reset busy", busy_v[0], 0);
        check("mid reset count", cnt_a, 0);
        check("mid reset ready", rdy[0], 0);
        sb.delete();
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        run_one(0, 9'h03C, 40);

        check("scoreboard empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
